multi_delay_timer: RTL and testbench

//  N-channel delay timer: each channel counts a programmable number of clk cycles after a start

---
 rtl/multi_delay_timer_pkg.sv | 8 +
 rtl/multi_delay_timer_if.sv | 24 ++
 rtl/delay_timer_channel.sv | 81 ++++++++
 rtl/edge_sync_pulse.sv | 33 +++
 rtl/multi_delay_timer.sv | 57 +++++
 tb/tb_multi_delay_timer.sv | 194 +++++++++++++++++++
 6 files changed

// File: rtl/multi_delay_timer_pkg.sv
// Shared constants for the multi-channel delay timer.
package multi_delay_timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  localparam int   SYNC_STAGES   = 2;

endpackage

// File: rtl/multi_delay_timer_if.sv
// Control/status bundle of the delay timer; master drives requests, slave is the timer.
interface multi_delay_timer_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   start;
  logic [N-1:0]   stop;
  logic [N-1:0]   clear_done;
  logic [N-1:0]   periodic;
  logic [N*W-1:0] delay_cnt;
  logic [N-1:0]   busy;
  logic [N-1:0]   done;
  logic [N-1:0]   done_pulse;

  modport master (
    output start, stop, clear_done, periodic, delay_cnt,
    input  busy, done, done_pulse
  );

  modport slave (
    input  start, stop, clear_done, periodic, delay_cnt,
    output busy, done, done_pulse
  );
endinterface

// File: rtl/delay_timer_channel.sv
// One timer channel: latched delay/mode, non-wrapping counter, stop > start > expiry > clear.
module delay_timer_channel
  import multi_delay_timer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_p,
  input  logic         t_p,
  input  logic         c_p,
  input  logic         periodic,
  input  logic [W-1:0] delay_cnt,
  output logic         busy,
  output logic         done,
  output logic         done_pulse
);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] dly_q, dly_d;
  logic         mode_q, mode_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pulse_q, pulse_d;
  logic         s_go;
  logic         expiry;

  // A zero delay start is dropped completely, so it cannot clear done either.
  assign s_go   = s_p && (delay_cnt != '0);
  assign expiry = busy_q && (count_q == dly_q);

  always_comb begin
    count_d = count_q;
    dly_d   = dly_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pulse_d = 1'b0;
    if (t_p) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (s_go) begin
      dly_d   = delay_cnt;
      mode_d  = periodic;
      count_d = W'(1);
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (expiry) begin
      pulse_d = 1'b1;
      done_d  = 1'b1;
      if (mode_q == MODE_PERIODIC) count_d = W'(1);
      else                         busy_d  = 1'b0;
    end else begin
      if (busy_q) count_d = count_q + W'(1);
      if (c_p)    done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      dly_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      dly_q   <= dly_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign done_pulse = pulse_q;

endmodule

// File: rtl/edge_sync_pulse.sv
// Synchronises asynchronous level inputs and emits a one-cycle pulse per rising edge.
module edge_sync_pulse
  import multi_delay_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] pulse
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/multi_delay_timer.sv
// N-channel delay timer: reset synchroniser, input edge conditioning and per-channel timers.
module multi_delay_timer
  import multi_delay_timer_pkg::*;
#(
  parameter int C_NUM_CHANNELS  = 4,
  parameter int C_COUNTER_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  multi_delay_timer_if.slave  bus
);

  logic [SYNC_STAGES-1:0]    rst_sync_q, rst_sync_d;
  logic                      rst_int;
  logic [C_NUM_CHANNELS-1:0] s_p, t_p, c_p;
  logic [C_NUM_CHANNELS-1:0] busy_w, done_w, pulse_w;

  // Assertion is immediate; release is delayed until it has crossed the synchroniser.
  always_comb rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= '1;
    else       rst_sync_q <= rst_sync_d;
  end

  assign rst_int = rst_sync_q[SYNC_STAGES-1];

  edge_sync_pulse #(.WIDTH(C_NUM_CHANNELS)) u_sync_start (
    .clk(clk), .rst(rst_int), .async_in(bus.start), .pulse(s_p)
  );
  edge_sync_pulse #(.WIDTH(C_NUM_CHANNELS)) u_sync_stop (
    .clk(clk), .rst(rst_int), .async_in(bus.stop), .pulse(t_p)
  );
  edge_sync_pulse #(.WIDTH(C_NUM_CHANNELS)) u_sync_clear (
    .clk(clk), .rst(rst_int), .async_in(bus.clear_done), .pulse(c_p)
  );

  for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_ch
    delay_timer_channel #(.W(C_COUNTER_WIDTH)) u_ch (
      .clk        (clk),
      .rst        (rst_int),
      .s_p        (s_p[i]),
      .t_p        (t_p[i]),
      .c_p        (c_p[i]),
      .periodic   (bus.periodic[i]),
      .delay_cnt  (bus.delay_cnt[i*C_COUNTER_WIDTH +: C_COUNTER_WIDTH]),
      .busy       (busy_w[i]),
      .done       (done_w[i]),
      .done_pulse (pulse_w[i])
    );
  end

  assign bus.busy       = busy_w;
  assign bus.done       = done_w;
  assign bus.done_pulse = pulse_w;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Bench for multi_delay_timer: a 4x32 instance and a 1x4 instance share clock and reset.
module tb_multi_delay_timer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];

  multi_delay_timer_if #(.N(4), .W(32)) bus ();
  multi_delay_timer_if #(.N(1), .W(4))  bus_s ();

  multi_delay_timer #(.C_NUM_CHANNELS(4), .C_COUNTER_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  multi_delay_timer #(.C_NUM_CHANNELS(1), .C_COUNTER_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // drivers
  task automatic set_bit(input int inst, input int sig, input int ch, input logic v);
    if (inst == 0) begin
      case (sig)
        0: bus.start[ch] = v;
        1: bus.stop[ch] = v;
        default: bus.clear_done[ch] = v;
      endcase
    end else begin
      case (sig)
        0: bus_s.start[0] = v;
        1: bus_s.stop[0] = v;
        default: bus_s.clear_done[0] = v;
      endcase
    end
  endtask

  task automatic kick(input int inst, input int sig, input int ch);
    set_bit(inst, sig, ch, 1'b1);
    @(negedge clk);
    set_bit(inst, sig, ch, 1'b0);
  endtask

  task automatic set_cfg(input int inst, input int ch, input logic [31:0] dly, input logic per);
    if (inst == 0) begin
      bus.delay_cnt[ch*32 +: 32] = dly;
      bus.periodic[ch] = per;
    end else begin
      bus_s.delay_cnt = dly[3:0];
      bus_s.periodic[0] = per;
    end
  endtask

  // Input rises at negedge k; conditioning makes s_p act on edge k+3, expiry on edge k+3+dly.
  task automatic start_ch(input int inst, input int ch, input logic [31:0] dly,
                          input logic per, input int n_exp);
    int k;
    k = cyc;
    set_cfg(inst, ch, dly, per);
    for (int j = 0; j < n_exp; j++)
      exp_q.push_back({32'(inst*16 + ch), 32'(k + 3 + int'(dly) * (j + 1))});
    kick(inst, 0, ch);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // scoreboard monitor
  task automatic mon_pop(input int code);
    logic [63:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    check("pulse", {32'(code), 32'(cyc)}, e);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.done_pulse[i] === 1'b1) mon_pop(i);
    if (bus_s.done_pulse[0] === 1'b1) mon_pop(16);
  end

  initial begin
    int k;
    reset = 1'b1;
    bus.start = '0; bus.stop = '0; bus.clear_done = '0; bus.periodic = '0; bus.delay_cnt = '0;
    bus_s.start = '0; bus_s.stop = '0; bus_s.clear_done = '0; bus_s.periodic = '0;
    bus_s.delay_cnt = '0;
    repeat (4) @(negedge clk);
    check("rst_busy", {bus_s.busy, bus.busy}, 5'h0);
    check("rst_done", {bus_s.done, bus.done}, 5'h0);
    check("rst_pulse", {bus_s.done_pulse, bus.done_pulse}, 5'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // one-shot ch0 delay 5; delay change while busy must be ignored
    k = cyc;
    start_ch(0, 0, 5, 1'b0, 1);
    wait_cyc(k + 5); set_cfg(0, 0, 7, 1'b0);
    wait_cyc(k + 7);  check("os_busy_pre", bus.busy[0], 1'b1); check("os_done_pre", bus.done[0], 1'b0);
    wait_cyc(k + 8);  check("os_busy_exp", bus.busy[0], 1'b0); check("os_done_exp", bus.done[0], 1'b1);
    wait_cyc(k + 14); check("os_done_sticky", bus.done[0], 1'b1);

    // periodic ch1 delay 3, four expiries then stop
    k = cyc;
    start_ch(0, 1, 3, 1'b1, 4);
    wait_cyc(k + 13); kick(0, 1, 1);
    wait_cyc(k + 15); check("per_busy", bus.busy[1], 1'b1); check("per_done", bus.done[1], 1'b1);
    wait_cyc(k + 16); check("stop_busy", bus.busy[1], 1'b0); check("stop_done", bus.done[1], 1'b0);
    wait_cyc(k + 26);

    // retrigger ch2: delay 10, re-start with delay 2 when count is 6
    k = cyc;
    start_ch(0, 2, 10, 1'b0, 0);
    wait_cyc(k + 6);
    start_ch(0, 2, 2, 1'b0, 1);
    wait_cyc(k + 10); check("rt_done_pre", bus.done[2], 1'b0);
    wait_cyc(k + 11); check("rt_done", bus.done[2], 1'b1); check("rt_busy", bus.busy[2], 1'b0);
    wait_cyc(k + 16); check("rt_no_orig", bus.busy[2], 1'b0);

    // delay 0 ignored, delay 1 expires one cycle after s_p
    k = cyc;
    start_ch(0, 3, 0, 1'b0, 0);
    wait_cyc(k + 6);  check("d0_busy", bus.busy[3], 1'b0);
    wait_cyc(k + 10); check("d0_busy_late", bus.busy[3], 1'b0);
    k = cyc;
    start_ch(0, 3, 1, 1'b0, 1);
    wait_cyc(k + 3); check("d1_busy", bus.busy[3], 1'b1);
    wait_cyc(k + 4); check("d1_done", bus.done[3], 1'b1); check("d1_busy_exp", bus.busy[3], 1'b0);

    // W=4 instance: delay 15 periodic, no wrap, two expiries then stop
    k = cyc;
    start_ch(1, 0, 15, 1'b1, 2);
    wait_cyc(k + 17); check("w4_busy", bus_s.busy[0], 1'b1); check("w4_done_pre", bus_s.done[0], 1'b0);
    wait_cyc(k + 33); check("w4_done", bus_s.done[0], 1'b1);
    wait_cyc(k + 35); kick(1, 1, 0);
    wait_cyc(k + 38); check("w4_stop", bus_s.busy[0], 1'b0);
    wait_cyc(k + 52);

    // stop collides with expiry
    k = cyc;
    start_ch(0, 0, 5, 1'b0, 0);
    wait_cyc(k + 5); kick(0, 1, 0);
    wait_cyc(k + 7); check("col_t_busy", bus.busy[0], 1'b1);
    wait_cyc(k + 8); check("col_t_busy2", bus.busy[0], 1'b0); check("col_t_done", bus.done[0], 1'b0);
    wait_cyc(k + 12);

    // clear collides with expiry, then a plain clear
    k = cyc;
    start_ch(0, 1, 4, 1'b0, 1);
    wait_cyc(k + 4); kick(0, 2, 1);
    wait_cyc(k + 7); check("col_c_done", bus.done[1], 1'b1);
    wait_cyc(k + 9); check("col_c_done2", bus.done[1], 1'b1);
    k = cyc;
    kick(0, 2, 1);
    wait_cyc(k + 2); check("clr_pre", bus.done[1], 1'b1);
    wait_cyc(k + 3); check("clr_done", bus.done[1], 1'b0);

    // reset mid-count on all channels
    for (int c = 0; c < 4; c++) start_ch(0, c, 20 + c, (c == 1), 0);
    repeat (6) @(negedge clk);
    check("pre_rst_busy", bus.busy, 4'hf);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", bus.busy, 4'h0);
    check("rst_mid_done", bus.done, 4'h0);
    check("rst_mid_pulse", bus.done_pulse, 4'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_busy", bus.busy, 4'h0);
    check("post_rst_done", bus.done, 4'h0);
    k = cyc;
    start_ch(0, 2, 3, 1'b0, 1);
    wait_cyc(k + 6); check("post_rst_run", bus.done[2], 1'b1);
    wait_cyc(k + 10);

    check("leftover", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
